// File: rtl/gemm_pkg.sv
// Shared opcodes, buffer-state encodings and FSM states for the GEMM
// CFU sequencer and its testbench.
package gemm_pkg;

  localparam logic [2:0] F_SETK  = 3'd0;
  localparam logic [2:0] F_START = 3'd1;
  localparam logic [2:0] F_PUSH  = 3'd2;
  localparam logic [2:0] F_READ  = 3'd3;
  localparam logic [2:0] F_CLR   = 3'd4;
  localparam logic [2:0] F_STAT  = 3'd5;

  localparam logic [7:0] BS_INIT = 8'd0;
  localparam logic [7:0] BS_DONE = 8'd1;

  localparam logic [31:0] RSP_BAD_OP = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_READ,
    ST_RESP
  } state_t;

endpackage

// File: rtl/gemm_seq_ctrl_if.sv
// CPU command/response handshake bundle between the CFU front end and the
// GEMM sequencer.
interface gemm_seq_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_funct;
  logic [31:0] cmd_in0;
  logic [31:0] cmd_in1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output cmd_valid, cmd_funct, cmd_in0, cmd_in1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_funct, cmd_in0, cmd_in1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/gemm_seq_ctrl_valid_delay_line.sv
// Delays the buffer DONE level by the buffer read latency so that it lines
// up with operands arriving at the systolic array.
module valid_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  generate
    if (DEPTH == 1) begin : g_single
      assign sr_d = din;
    end else begin : g_multi
      assign sr_d = {sr_q[DEPTH-2:0], din};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/gemm_seq_ctrl.sv
// Decodes CPU commands into A/B buffer strobes, sequences the K-long operand
// stream plus array drain, and answers the CPU when the work is complete.
module gemm_seq_ctrl
  import gemm_pkg::*;
#(
  parameter int IDX_W     = 16,
  parameter int RD_LAT    = 2,
  parameter int DRAIN_CYC = 7,
  parameter int ACC_AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  gemm_seq_ctrl_if.slave    cpu,
  output logic [2:0]        buf_funct,
  output logic [31:0]       buf_in0,
  output logic [31:0]       buf_in1,
  output logic [7:0]        buf_state,
  output logic [IDX_W-1:0]  k_len,
  output logic              sa_valid,
  output logic              sa_clear,
  output logic [ACC_AW-1:0] acc_addr,
  input  logic [31:0]       acc_data,
  output logic              busy
);

  // DRAIN covers the read-latency tail of sa_valid plus the array flush.
  localparam int DRAIN_TOT = RD_LAT + DRAIN_CYC;
  localparam int DCNT_W    = $clog2(DRAIN_TOT + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN_TOT - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  k_len_q, k_len_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [2:0]        buf_funct_q, buf_funct_d;
  logic [31:0]       buf_in0_q, buf_in0_d;
  logic [31:0]       buf_in1_q, buf_in1_d;
  logic [7:0]        buf_state_q, buf_state_d;
  logic              sa_clear_q, sa_clear_d;
  logic [ACC_AW-1:0] acc_addr_q, acc_addr_d;

  logic              accept;
  logic              go_rsp;
  logic [31:0]       rsp_val;
  logic [IDX_W:0]    k_plus1;

  assign accept  = cpu.cmd_valid & cmd_ready_q;
  // Extra bit keeps k_len=all-ones from wrapping to a zero count.
  assign k_plus1 = (IDX_W+1)'(k_len_q) + (IDX_W+1)'(1);

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    cnt_d       = cnt_q;
    dcnt_d      = dcnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    buf_funct_d = 3'd0;
    buf_in0_d   = buf_in0_q;
    buf_in1_d   = buf_in1_q;
    buf_state_d = buf_state_q;
    sa_clear_d  = 1'b0;
    acc_addr_d  = acc_addr_q;
    go_rsp      = 1'b0;
    rsp_val     = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          buf_in0_d = cpu.cmd_in0;
          buf_in1_d = cpu.cmd_in1;
          case (cpu.cmd_funct)
            F_SETK: begin
              k_len_d = cpu.cmd_in0[IDX_W-1:0];
              go_rsp  = 1'b1;
            end
            F_PUSH, F_CLR: begin
              buf_funct_d = cpu.cmd_funct;
              go_rsp      = 1'b1;
            end
            F_STAT: begin
              rsp_val = 32'(k_len_q);
              go_rsp  = 1'b1;
            end
            F_START: begin
              sa_clear_d  = 1'b1;
              buf_state_d = BS_DONE;
              cnt_d       = '0;
              state_d     = ST_STREAM;
            end
            F_READ: begin
              acc_addr_d = cpu.cmd_in0[ACC_AW-1:0];
              state_d    = ST_READ;
            end
            default: begin
              rsp_val = RSP_BAD_OP;
              go_rsp  = 1'b1;
            end
          endcase
        end
      end
      ST_STREAM: begin
        if (cnt_q == k_len_q) begin
          buf_state_d = BS_INIT;
          dcnt_d      = '0;
          state_d     = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == DCNT_LAST) begin
          rsp_val = 32'(k_plus1);
          go_rsp  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      ST_READ: begin
        rsp_val = acc_data;
        go_rsp  = 1'b1;
      end
      ST_RESP: begin
        if (cpu.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_rsp) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rsp_val;
      state_d     = ST_RESP;
    end

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_len_q     <= '0;
      cnt_q       <= '0;
      dcnt_q      <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      buf_funct_q <= '0;
      buf_in0_q   <= '0;
      buf_in1_q   <= '0;
      buf_state_q <= BS_INIT;
      sa_clear_q  <= 1'b0;
      acc_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      buf_funct_q <= buf_funct_d;
      buf_in0_q   <= buf_in0_d;
      buf_in1_q   <= buf_in1_d;
      buf_state_q <= buf_state_d;
      sa_clear_q  <= sa_clear_d;
      acc_addr_q  <= acc_addr_d;
    end
  end

  valid_delay_line #(.DEPTH(RD_LAT)) u_vld_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (buf_state_q == BS_DONE),
    .dout  (sa_valid)
  );

  assign cpu.cmd_ready = cmd_ready_q;
  assign cpu.rsp_valid = rsp_valid_q;
  assign cpu.rsp_data  = rsp_data_q;
  assign buf_funct     = buf_funct_q;
  assign buf_in0       = buf_in0_q;
  assign buf_in1       = buf_in1_q;
  assign buf_state     = buf_state_q;
  assign k_len         = k_len_q;
  assign sa_clear      = sa_clear_q;
  assign acc_addr      = acc_addr_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_gemm_seq_ctrl.sv
// Directed bench for gemm_seq_ctrl: command decode, stream/drain timing,
// accumulator read with back-pressure and asynchronous reset mid-stream.
module tb_gemm_seq_ctrl;
  import gemm_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [2:0]  buf_funct;
  logic [31:0] buf_in0;
  logic [31:0] buf_in1;
  logic [7:0]  buf_state;
  logic [15:0] k_len;
  logic        sa_valid;
  logic        sa_clear;
  logic [3:0]  acc_addr;
  logic [31:0] acc_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  gemm_seq_ctrl_if cpu ();

  gemm_seq_ctrl #(
    .IDX_W(16), .RD_LAT(2), .DRAIN_CYC(7), .ACC_AW(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu       (cpu),
    .buf_funct (buf_funct),
    .buf_in0   (buf_in0),
    .buf_in1   (buf_in1),
    .buf_state (buf_state),
    .k_len     (k_len),
    .sa_valid  (sa_valid),
    .sa_clear  (sa_clear),
    .acc_addr  (acc_addr),
    .acc_data  (acc_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulator model: address 5 holds DEADBEEF, others a tagged address.
  always_comb begin
    acc_data = 32'hA5A5_0000 | 32'(acc_addr);
    if (acc_addr == 4'd5) acc_data = 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Returns one cycle after the accepting edge (cycle T+1).
  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!cpu.cmd_ready && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_ready_before_send", cpu.cmd_ready, 1);
    cpu.cmd_valid = 1'b1;
    cpu.cmd_funct = f;
    cpu.cmd_in0   = a;
    cpu.cmd_in1   = b;
    tick();
    cpu.cmd_valid = 1'b0;
    cpu.cmd_funct = 3'd0;
    cpu.cmd_in0   = 32'h0000_0055;
    cpu.cmd_in1   = 32'h0;
  endtask

  // Simple opcode with rsp_ready high: response at T+1, IDLE at T+2.
  task automatic simple(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] exp_data);
    send(f, a, 32'h0);
    chk({tag, "_rsp_valid"}, cpu.rsp_valid, 1);
    chk({tag, "_rsp_data"}, cpu.rsp_data, exp_data);
    chk({tag, "_cmd_ready_low"}, cpu.cmd_ready, 0);
    tick();
    chk({tag, "_back_idle"}, cpu.cmd_ready, 1);
  endtask

  task automatic run_start(input int k, input int limit);
    int cyc = 1;
    int ndone = 0;
    int nsa = 0;
    int nclr = 0;
    int fdone = -1;
    int fsa = -1;
    int rcyc = -1;
    send(F_START, 32'h0, 32'h0);
    while (cyc <= limit) begin
      if (buf_state == BS_DONE) begin
        ndone++;
        if (fdone < 0) fdone = cyc;
      end
      if (sa_valid) begin
        nsa++;
        if (fsa < 0) fsa = cyc;
      end
      if (sa_clear) nclr++;
      if (cpu.rsp_valid) begin
        rcyc = cyc;
        break;
      end
      tick();
      cyc++;
    end
    chk("start_done_cycles", 32'(ndone), 32'(k + 1));
    chk("start_first_done", 32'(fdone), 32'd1);
    chk("start_sa_cycles", 32'(nsa), 32'(k + 1));
    chk("start_first_sa", 32'(fsa), 32'd3);
    chk("start_clear_pulses", 32'(nclr), 32'd1);
    chk("start_rsp_cycle", 32'(rcyc), 32'(k + 11));
    chk("start_rsp_data", cpu.rsp_data, 32'(k + 1));
    tick();
    chk("start_back_idle", cpu.cmd_ready, 1);
  endtask

  initial begin
    cpu.cmd_valid = 1'b0;
    cpu.cmd_funct = 3'd0;
    cpu.cmd_in0   = 32'h0;
    cpu.cmd_in1   = 32'h0;
    cpu.rsp_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) tick();

    chk("rst_cmd_ready", cpu.cmd_ready, 1);
    chk("rst_rsp_valid", cpu.rsp_valid, 0);
    chk("rst_rsp_data", cpu.rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_buf_state", buf_state, 0);
    chk("rst_sa_valid", sa_valid, 0);
    chk("rst_k_len", k_len, 0);
    chk("rst_buf_funct", buf_funct, 0);
    rst_n = 1'b1;
    tick();

    send(F_SETK, 32'd7, 32'h0);
    chk("setk_rsp_valid", cpu.rsp_valid, 1);
    chk("setk_rsp_data", cpu.rsp_data, 0);
    chk("setk_k_len", k_len, 7);
    chk("setk_busy", busy, 1);
    tick();
    chk("setk_idle", cpu.cmd_ready, 1);

    simple("stat7", F_STAT, 32'h0, 32'h0000_0007);

    for (int i = 0; i < 4; i++) begin
      send(F_PUSH, 32'h0102_0304, 32'h0A0B_0C00 + 32'(i));
      chk("push_funct", buf_funct, 2);
      chk("push_in0", buf_in0, 32'h0102_0304);
      chk("push_in1", buf_in1, 32'h0A0B_0C00 + 32'(i));
      chk("push_rsp_data", cpu.rsp_data, 0);
      tick();
      chk("push_funct_gone", buf_funct, 0);
    end

    send(F_CLR, 32'h0, 32'h0);
    chk("clr_funct", buf_funct, 4);
    tick();
    chk("clr_funct_gone", buf_funct, 0);

    run_start(7, 100);

    cpu.rsp_ready = 1'b0;
    send(F_READ, 32'd5, 32'h0);
    chk("read_addr", acc_addr, 5);
    chk("read_rsp_early", cpu.rsp_valid, 0);
    // Garbage command while busy must be ignored.
    cpu.cmd_valid = 1'b1;
    cpu.cmd_funct = F_SETK;
    cpu.cmd_in0   = 32'd99;
    tick();
    chk("read_rsp_valid", cpu.rsp_valid, 1);
    chk("read_rsp_data", cpu.rsp_data, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_rsp_valid", cpu.rsp_valid, 1);
      chk("hold_rsp_data", cpu.rsp_data, 32'hDEAD_BEEF);
      chk("hold_cmd_ready", cpu.cmd_ready, 0);
    end
    cpu.cmd_valid = 1'b0;
    cpu.rsp_ready = 1'b1;
    tick();
    chk("hold_released", cpu.cmd_ready, 1);
    chk("hold_rsp_dropped", cpu.rsp_valid, 0);
    chk("ignored_setk", k_len, 7);

    send(F_READ, 32'd9, 32'h0);
    chk("read9_rsp_early", cpu.rsp_valid, 0);
    tick();
    chk("read9_rsp_data", cpu.rsp_data, 32'hA5A5_0009);
    tick();
    chk("read9_idle", cpu.cmd_ready, 1);

    simple("bad_op", 3'd6, 32'h0, 32'hFFFF_FFFF);

    simple("setk0", F_SETK, 32'h0, 32'h0);
    run_start(0, 100);

    simple("setk_max", F_SETK, 32'h0000_FFFF, 32'h0);
    run_start(65535, 70000);
    simple("stat_max", F_STAT, 32'h0, 32'h0000_FFFF);

    simple("setk7b", F_SETK, 32'd7, 32'h0);
    send(F_START, 32'h0, 32'h0);
    repeat (3) tick();
    chk("mid_stream_state", buf_state, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_buf_state", buf_state, 0);
    chk("arst_sa_valid", sa_valid, 0);
    chk("arst_cmd_ready", cpu.cmd_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_rsp_valid", cpu.rsp_valid, 0);
    chk("arst_k_len", k_len, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_start(0, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
